// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side issues start with operands; the slave side returns status and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, in1, in2,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// The subtract is an add of the shifted partial remainder with the inverted
// divisor and carry-in 1; the carry-out means "no borrow" (trial fits).
// Results are held in dedicated registers so intermediate values never show.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_zero_div;
    logic             w_last;
    logic             w_qbit;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH:0]   w_rem_nxt;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_zero_div = (bus.in2 == {WIDTH{1'b0}});
    assign w_last     = (r_state == S_CALC) && (r_cnt == CW'(1));

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign w_shift   = (r_rem << 1) | {{WIDTH{1'b0}}, r_dividend[WIDTH-1]};
    assign w_trial   = {1'b0, w_shift} + {1'b0, ~{1'b0, r_divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_qbit    = w_trial[WIDTH+1];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH:0] : w_shift;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: zero divisor skips the iteration entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done can be registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt == S_IDLE) begin
            w_busy_nxt = 1'b0;
        end else begin
            w_busy_nxt = 1'b1;
        end
        if (w_state_nxt == S_DONE) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Iteration datapath: load operands on accept, shift/subtract while calculating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_rem      <= {(WIDTH+1){1'b0}};
            r_cnt      <= {CW{1'b0}};
        end else if (w_accept) begin
            r_dividend <= bus.in1;
            r_divisor  <= bus.in2;
            r_rem      <= {(WIDTH+1){1'b0}};
            r_cnt      <= CW'(WIDTH);
        end else if (r_state == S_CALC) begin
            r_dividend <= {r_dividend[WIDTH-2:0], w_qbit};
            r_rem      <= w_rem_nxt;
            r_cnt      <= r_cnt - CW'(1);
        end
    end

    // Result registers: written only when DONE is entered, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= {WIDTH{1'b0}};
            r_remo <= {WIDTH{1'b0}};
            r_dbz  <= 1'b0;
        end else if (w_accept && w_zero_div) begin
            r_quot <= {WIDTH{1'b1}};
            r_remo <= bus.in1;
            r_dbz  <= 1'b1;
        end else if (w_last) begin
            r_quot <= {r_dividend[WIDTH-2:0], w_qbit};
            r_remo <= w_rem_nxt[WIDTH-1:0];
            r_dbz  <= 1'b0;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
endmodule
